// File: rtl/spi_slave_interface_if.sv
// Bundle of the SPI wires and the user-side tx/rx handshake of spi_slave_interface.
interface spi_slave_interface_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  sclk;
    logic                  ss;
    logic                  mosi;
    logic                  miso;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_valid;
    logic                  tx_ready;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_valid;
    logic                  busy;
    logic                  tx_underrun;

    modport slave (
        input  sclk, ss, mosi, tx_data, tx_valid,
        output miso, tx_ready, rx_data, rx_valid, busy, tx_underrun
    );

    modport master (
        output sclk, ss, mosi, tx_data, tx_valid,
        input  miso, tx_ready, rx_data, rx_valid, busy, tx_underrun
    );
endinterface

// File: rtl/spi_slave_interface.sv
// SPI mode-3 slave, one DATA_WIDTH frame at a time, oversampled entirely in the clk domain.
// A one-deep holding register feeds the transmit shifter at each frame load.
module spi_slave_interface #(
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    SYNC_STAGES = 2,
    parameter logic [DATA_WIDTH-1:0] IDLE_FILL   = {DATA_WIDTH{1'b1}}
) (
    input logic                   clk,
    input logic                   rst,
    spi_slave_interface_if.slave  bus
);
    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DATA_WIDTH);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t                  state, state_nxt;
    logic [SYNC_STAGES-1:0]  sclk_q, ss_q, mosi_q;
    logic                    sclk_d, ss_d;
    logic                    sclk_s, ss_s, mosi_s;
    logic                    s_rise, s_fall, ss_fall;
    logic [CW-1:0]           bit_cnt;
    logic [DATA_WIDTH-1:0]   shift_tx, shift_rx, hold_data;
    logic                    hold_full;
    logic                    accept, do_load, complete;

    // All three inputs idle high, so the synchronizers reset to 1 to avoid phantom edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_q <= '1;
            ss_q   <= '1;
            mosi_q <= '1;
            sclk_d <= 1'b1;
            ss_d   <= 1'b1;
        end else begin
            sclk_q <= {sclk_q[SYNC_STAGES-2:0], bus.sclk};
            ss_q   <= {ss_q[SYNC_STAGES-2:0], bus.ss};
            mosi_q <= {mosi_q[SYNC_STAGES-2:0], bus.mosi};
            sclk_d <= sclk_s;
            ss_d   <= ss_s;
        end
    end

    assign sclk_s  = sclk_q[SYNC_STAGES-1];
    assign ss_s    = ss_q[SYNC_STAGES-1];
    assign mosi_s  = mosi_q[SYNC_STAGES-1];
    assign s_rise  = sclk_s & ~sclk_d;
    assign s_fall  = ~sclk_s & sclk_d;
    assign ss_fall = ~ss_s & ss_d;
    assign accept  = bus.tx_valid & ~hold_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // A finished byte is always delivered, even if ss has just risen; it only skips the reload.
    always_comb begin
        state_nxt = state;
        do_load   = 1'b0;
        complete  = 1'b0;
        case (state)
            IDLE: begin
                if (ss_fall) begin
                    do_load   = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (bit_cnt == FULL) begin
                    complete = 1'b1;
                    if (ss_s) state_nxt = IDLE;
                    else      do_load   = 1'b1;
                end else if (ss_s) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.miso        <= 1'b1;
            bus.rx_data     <= '0;
            bus.rx_valid    <= 1'b0;
            bus.tx_underrun <= 1'b0;
            bit_cnt         <= '0;
            shift_tx        <= '0;
            shift_rx        <= '0;
            hold_data       <= '0;
            hold_full       <= 1'b0;
        end else begin
            bus.rx_valid    <= 1'b0;
            bus.tx_underrun <= 1'b0;
            // Load looks at the hold before this cycle's accept, so a same-cycle byte waits a frame.
            if (do_load) begin
                if (hold_full) begin
                    shift_tx  <= hold_data;
                    hold_full <= 1'b0;
                end else begin
                    shift_tx        <= IDLE_FILL;
                    bus.tx_underrun <= 1'b1;
                end
            end
            if (accept) begin
                hold_data <= bus.tx_data;
                hold_full <= 1'b1;
            end
            if (state == IDLE) begin
                bus.miso <= 1'b1;
                bit_cnt  <= '0;
            end else if (complete) begin
                bus.rx_data  <= shift_rx;
                bus.rx_valid <= 1'b1;
                bit_cnt      <= '0;
                if (ss_s) bus.miso <= 1'b1;
            end else if (ss_s) begin
                bus.miso <= 1'b1;
                bit_cnt  <= '0;
            end else begin
                if (s_fall) begin
                    bus.miso <= shift_tx[DATA_WIDTH-1];
                    shift_tx <= {shift_tx[DATA_WIDTH-2:0], 1'b0};
                end
                if (s_rise) begin
                    shift_rx <= {shift_rx[DATA_WIDTH-2:0], mosi_s};
                    bit_cnt  <= bit_cnt + 1'b1;
                end
            end
        end
    end

    assign bus.tx_ready = ~hold_full;
    assign bus.busy     = (state == SHIFT);
endmodule

// File: tb/tb_spi_slave_interface.sv
// Directed bench for spi_slave_interface: a behavioural mode-3 master plus hand-computed bytes.
module tb_spi_slave_interface;
    localparam int HALF = 50;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   compared = 0;
    int   mismatched = 0;
    int   rx_cnt = 0;
    int   uf_cnt = 0;
    logic [7:0] rx_log [0:31];

    spi_slave_interface_if #(.DATA_WIDTH(8)) bus ();

    spi_slave_interface #(.DATA_WIDTH(8), .SYNC_STAGES(2), .IDLE_FILL(8'hFF)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.rx_valid) begin
            rx_log[rx_cnt % 32] <= bus.rx_data;
            rx_cnt <= rx_cnt + 1;
        end
        if (bus.tx_underrun) uf_cnt <= uf_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] d);
        @(negedge clk);
        bus.tx_data  = d;
        bus.tx_valid = 1'b1;
        @(negedge clk);
        bus.tx_valid = 1'b0;
    endtask

    task automatic select();
        @(negedge clk);
        bus.ss = 1'b0;
        #(2 * HALF);
    endtask

    // Shift n bits MSB first; with rel set, ss rises one clk after the last sclk rise.
    task automatic shift_byte(input logic [7:0] tx, input int n, input bit rel,
                              output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i >= 8 - n; i--) begin
            bus.sclk = 1'b0;
            bus.mosi = tx[i];
            #HALF;
            bus.sclk = 1'b1;
            rx[i] = bus.miso;
            if (rel && i == 8 - n) begin
                #10;
                bus.ss = 1'b1;
                #(HALF - 10);
            end else begin
                #HALF;
            end
        end
    endtask

    initial begin
        logic [7:0] g1, g2;
        int r0, u0;
        bus.sclk = 1'b1; bus.ss = 1'b1; bus.mosi = 1'b1;
        bus.tx_data = 8'h00; bus.tx_valid = 1'b0;

        #23;
        check("rst_miso", 32'(bus.miso), 1);
        check("rst_rx_data", 32'(bus.rx_data), 0);
        check("rst_rx_valid", 32'(bus.rx_valid), 0);
        check("rst_tx_ready", 32'(bus.tx_ready), 1);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_underrun", 32'(bus.tx_underrun), 0);
        #10 rst = 1'b0;
        #40;

        // 1: held 3C out, A5 in
        push(8'h3C);
        check("t1_ready_full", 32'(bus.tx_ready), 0);
        r0 = rx_cnt; u0 = uf_cnt;
        select();
        check("t1_ready_after_load", 32'(bus.tx_ready), 1);
        check("t1_busy", 32'(bus.busy), 1);
        shift_byte(8'hA5, 8, 1'b1, g1);
        #100;
        check("t1_rx_pulses", 32'(rx_cnt - r0), 1);
        check("t1_rx_data", 32'(bus.rx_data), 32'(8'hA5));
        check("t1_miso_seen", 32'(g1), 32'(8'h3C));
        check("t1_underruns", 32'(uf_cnt - u0), 0);
        check("t1_idle_busy", 32'(bus.busy), 0);
        check("t1_idle_miso", 32'(bus.miso), 1);

        // 2: back-to-back frames under one ss
        push(8'h11);
        r0 = rx_cnt; u0 = uf_cnt;
        select();
        push(8'h22);
        shift_byte(8'h12, 8, 1'b0, g1);
        shift_byte(8'h34, 8, 1'b1, g2);
        #100;
        check("t2_rx_pulses", 32'(rx_cnt - r0), 2);
        check("t2_rx_first", 32'(rx_log[r0 % 32]), 32'(8'h12));
        check("t2_rx_second", 32'(rx_log[(r0 + 1) % 32]), 32'(8'h34));
        check("t2_miso_first", 32'(g1), 32'(8'h11));
        check("t2_miso_second", 32'(g2), 32'(8'h22));
        check("t2_underruns", 32'(uf_cnt - u0), 0);

        // 3: nothing held -> IDLE_FILL and one underrun
        r0 = rx_cnt; u0 = uf_cnt;
        select();
        shift_byte(8'h00, 8, 1'b1, g1);
        #100;
        check("t3_miso_fill", 32'(g1), 32'(8'hFF));
        check("t3_underruns", 32'(uf_cnt - u0), 1);
        check("t3_rx_data", 32'(bus.rx_data), 0);
        check("t3_rx_pulses", 32'(rx_cnt - r0), 1);

        // 4: aborted frame after 4 bits, then a clean 5A frame
        r0 = rx_cnt;
        select();
        shift_byte(8'hF0, 4, 1'b1, g1);
        #100;
        check("t4_no_rx", 32'(rx_cnt - r0), 0);
        check("t4_rx_kept", 32'(bus.rx_data), 0);
        check("t4_busy", 32'(bus.busy), 0);
        check("t4_miso", 32'(bus.miso), 1);
        select();
        shift_byte(8'h5A, 8, 1'b1, g1);
        #100;
        check("t4_rx_5a", 32'(bus.rx_data), 32'(8'h5A));
        check("t4_rx_pulse", 32'(rx_cnt - r0), 1);

        // 5: async reset in the middle of bit 5
        push(8'h00);
        select();
        push(8'h81);
        shift_byte(8'hFF, 5, 1'b0, g1);
        check("t5_pre_busy", 32'(bus.busy), 1);
        check("t5_pre_miso", 32'(bus.miso), 0);
        check("t5_pre_ready", 32'(bus.tx_ready), 0);
        #3 rst = 1'b1;
        #1;
        check("t5_rst_miso", 32'(bus.miso), 1);
        check("t5_rst_rx_data", 32'(bus.rx_data), 0);
        check("t5_rst_busy", 32'(bus.busy), 0);
        check("t5_rst_ready", 32'(bus.tx_ready), 1);
        check("t5_rst_rx_valid", 32'(bus.rx_valid), 0);
        #16 bus.ss = 1'b1;
        #20 rst = 1'b0;
        #100;
        push(8'h81);
        select();
        shift_byte(8'hC6, 8, 1'b1, g1);
        #100;
        check("t5_rx_c6", 32'(bus.rx_data), 32'(8'hC6));
        check("t5_miso_81", 32'(g1), 32'(8'h81));

        // 6: tx_valid while full is ignored
        push(8'h77);
        push(8'h99);
        check("t6_ready_full", 32'(bus.tx_ready), 0);
        select();
        shift_byte(8'h0F, 8, 1'b1, g1);
        #100;
        check("t6_miso_77", 32'(g1), 32'(8'h77));
        check("t6_rx_0f", 32'(bus.rx_data), 32'(8'h0F));
        check("t6_ready_empty", 32'(bus.tx_ready), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
